// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run/step/breakpoint controller and the core.
package cpu_run_ctrl_pkg;

  localparam logic [31:0] CPU_HALT_INST = 32'h8000_0000;
  localparam int unsigned CPU_STEP_W    = 16;
  localparam int unsigned CPU_CNT_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_STEP  = 2'd1,
    OP_STOP  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    RSN_NONE       = 3'd0,
    RSN_STOP       = 3'd1,
    RSN_STEP_DONE  = 3'd2,
    RSN_BREAKPOINT = 3'd3,
    RSN_HALT       = 3'd4
  } stop_reason_e;

  // RUN and STEP are the only states in which the core may be enabled.
  function automatic logic is_active(run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned W = CPU_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: drives the core's global_en from debug
// commands and stops on step completion, breakpoint, STOP or the halt opcode.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_INST = CPU_HALT_INST,
  parameter int unsigned STEP_W    = CPU_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_step_n,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  output logic              global_en,
  output logic [1:0]        state,
  output logic [2:0]        stop_reason,
  output logic              cmd_err,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       inst_cnt
);

  run_state_e        state_q, state_n;
  stop_reason_e      reason_q, reason_n;
  logic [STEP_W-1:0] step_left_q, step_left_n;
  logic              skip_q, skip_n;
  logic              err_q, err_n;
  logic              cnt_clr;

  logic    active;
  logic    bp_hit;
  logic    halt_now;
  logic    last_step;
  cmd_op_e op;

  // skip masks the breakpoint so the instruction parked at bp_addr runs on resume.
  always_comb begin
    op        = cmd_op_e'(cmd_op);
    active    = is_active(state_q);
    bp_hit    = bp_en && (pc == bp_addr) && !skip_q;
    global_en = active && !bp_hit;
    halt_now  = global_en && (inst == HALT_INST);
    last_step = (state_q == ST_STEP) && (step_left_q == STEP_W'(1));
  end

  // Next-state, stop reason, step/skip bookkeeping and command legality.
  always_comb begin
    state_n     = state_q;
    reason_n    = reason_q;
    step_left_n = step_left_q;
    skip_n      = skip_q;
    err_n       = 1'b0;
    cnt_clr     = 1'b0;

    if (global_en) begin
      skip_n = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_RUN: begin
              state_n  = ST_RUN;
              reason_n = RSN_NONE;
              skip_n   = 1'b1;
            end
            OP_STEP: begin
              state_n     = ST_STEP;
              reason_n    = RSN_NONE;
              skip_n      = 1'b1;
              step_left_n = (cmd_step_n == '0) ? STEP_W'(1) : cmd_step_n;
            end
            OP_CLEAR: begin
              cnt_clr  = 1'b1;
              reason_n = RSN_NONE;
            end
            default: ;
          endcase
        end
      end

      ST_RUN, ST_STEP: begin
        if (cmd_valid && (op != OP_STOP)) begin
          err_n = 1'b1;
        end
        if (global_en && (state_q == ST_STEP)) begin
          step_left_n = step_left_q - STEP_W'(1);
        end
        // Priority: halt, breakpoint, STOP, step completion.
        if (halt_now) begin
          state_n  = ST_HALTED;
          reason_n = RSN_HALT;
        end else if (bp_hit) begin
          state_n  = ST_IDLE;
          reason_n = RSN_BREAKPOINT;
        end else if (cmd_valid && (op == OP_STOP)) begin
          state_n  = ST_IDLE;
          reason_n = RSN_STOP;
        end else if (global_en && last_step) begin
          state_n  = ST_IDLE;
          reason_n = RSN_STEP_DONE;
        end
      end

      ST_HALTED: begin
        if (cmd_valid) begin
          if (op == OP_CLEAR) begin
            state_n  = ST_IDLE;
            reason_n = RSN_NONE;
            cnt_clr  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      reason_q    <= RSN_NONE;
      step_left_q <= '0;
      skip_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      reason_q    <= reason_n;
      step_left_q <= step_left_n;
      skip_q      <= skip_n;
      err_q       <= err_n;
    end
  end

  sat_counter #(.W(32)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .inc (active),
    .clr (cnt_clr),
    .cnt (cycle_cnt)
  );

  sat_counter #(.W(32)) u_inst_cnt (
    .clk (clk),
    .rst (rst),
    .inc (global_en),
    .clr (cnt_clr),
    .cnt (inst_cnt)
  );

  assign state       = state_q;
  assign stop_reason = reason_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with a tiny fetch-PC model of the core.
module tb_cpu_run_ctrl;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;
  localparam logic [31:0] HALT    = 32'h8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // {state, stop_reason, inst_cnt, cycle_cnt, enabled cycles seen by bench}
  typedef logic [100:0] outcome_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_step_n = 16'd0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        global_en;
  logic [1:0]  state;
  logic [2:0]  stop_reason;
  logic        cmd_err;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;

  logic        pc_ld = 1'b0;
  logic [31:0] pc_ld_val = 32'd0;
  logic [31:0] halt_pc = 32'hFFFF_FFFF;

  int          checks = 0;
  int          errors = 0;
  int unsigned en_cnt = 0;
  outcome_t    sb[$];
  outcome_t    got, expv;
  bit          to;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_step_n  (cmd_step_n),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .inst        (inst),
    .global_en   (global_en),
    .state       (state),
    .stop_reason (stop_reason),
    .cmd_err     (cmd_err),
    .cycle_cnt   (cycle_cnt),
    .inst_cnt    (inst_cnt)
  );

  // Core model: PC advances by one word on every enabled cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'd0;
    else if (pc_ld) pc <= pc_ld_val;
    else if (global_en) pc <= pc + 32'd4;
  end
  assign inst = (pc == halt_pc) ? HALT : NOP;

  task automatic step();
    @(negedge clk);
    if (global_en) en_cnt++;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    pc_ld     = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] n);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_step_n = n;
    step();
  endtask

  task automatic load_pc(input logic [31:0] a);
    pc_ld     = 1'b1;
    pc_ld_val = a;
    step();
  endtask

  task automatic run_until_stop(output bit timed_out);
    for (int i = 0; i < 60; i++) begin
      if (state != 2'd1 && state != 2'd2) break;
      step();
    end
    timed_out = (state == 2'd1 || state == 2'd2);
  endtask

  task automatic test_reset();
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if (stop_reason !== 3'd0) begin errors++; $display("FAIL reset_reason got=%0d exp=0", stop_reason); end
    checks++;
    if ({cmd_err, global_en} !== 2'b00) begin errors++; $display("FAIL reset_err_en got=%b exp=00", {cmd_err, global_en}); end
    checks++;
    if ({cycle_cnt, inst_cnt} !== 64'd0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", {cycle_cnt, inst_cnt}); end
  endtask

  task automatic test_step3();
    load_pc(32'd0);
    en_cnt = 0;
    sb.push_back({2'd0, 3'd2, 32'd3, 32'd3, 32'd3});
    send(OP_STEP, 16'd3);
    run_until_stop(to);
    checks++;
    if (to) begin errors++; $display("FAIL step3_timeout state=%0d exp=0", state); end
    got = {state, stop_reason, inst_cnt, cycle_cnt, en_cnt};
    expv = sb.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("FAIL step3_outcome got=%h exp=%h", got, expv); end
  endtask

  task automatic test_breakpoint();
    send(OP_CLEAR, 16'd0);
    load_pc(32'd0);
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    en_cnt  = 0;
    sb.push_back({2'd0, 3'd3, 32'd4, 32'd5, 32'd4});
    send(OP_RUN, 16'd0);
    run_until_stop(to);
    checks++;
    if (to) begin errors++; $display("FAIL bp_timeout state=%0d exp=0", state); end
    got = {state, stop_reason, inst_cnt, cycle_cnt, en_cnt};
    expv = sb.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("FAIL bp_outcome got=%h exp=%h", got, expv); end
    checks++;
    if (pc !== 32'h10) begin errors++; $display("FAIL bp_pc got=%h exp=10", pc); end
    // Resume: the instruction at the breakpoint must execute.
    send(OP_RUN, 16'd0);
    #2;
    checks++;
    if (global_en !== 1'b1) begin errors++; $display("FAIL bp_resume_en got=%b exp=1", global_en); end
    step();
    checks++;
    if ({state, inst_cnt} !== {2'd1, 32'd5}) begin
      errors++; $display("FAIL bp_resume got=%h exp=%h", {state, inst_cnt}, {2'd1, 32'd5});
    end
    sb.push_back({2'd0, 3'd1, 32'd6, 32'd7, 32'd6});
    send(OP_STOP, 16'd0);
    got = {state, stop_reason, inst_cnt, cycle_cnt, en_cnt};
    expv = sb.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("FAIL stop_outcome got=%h exp=%h", got, expv); end
    bp_en = 1'b0;
  endtask

  task automatic test_halt();
    send(OP_CLEAR, 16'd0);
    load_pc(32'd0);
    halt_pc = 32'h8;
    en_cnt  = 0;
    sb.push_back({2'd3, 3'd4, 32'd3, 32'd3, 32'd3});
    send(OP_RUN, 16'd0);
    run_until_stop(to);
    checks++;
    if (to) begin errors++; $display("FAIL halt_timeout state=%0d exp=3", state); end
    got = {state, stop_reason, inst_cnt, cycle_cnt, en_cnt};
    expv = sb.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("FAIL halt_outcome got=%h exp=%h", got, expv); end
    send(OP_RUN, 16'd0);
    checks++;
    if ({cmd_err, state} !== {1'b1, 2'd3}) begin errors++; $display("FAIL halt_run_err got=%b exp=111", {cmd_err, state}); end
    step();
    checks++;
    if (cmd_err !== 1'b0) begin errors++; $display("FAIL halt_err_pulse got=%b exp=0", cmd_err); end
    send(OP_CLEAR, 16'd0);
    checks++;
    if ({state, stop_reason, inst_cnt, cycle_cnt} !== 69'd0) begin
      errors++; $display("FAIL halt_clear got=%h exp=0", {state, stop_reason, inst_cnt, cycle_cnt});
    end
    halt_pc = 32'hFFFF_FFFF;
  endtask

  task automatic test_stop_vs_halt();
    load_pc(32'd0);
    halt_pc = 32'h8;
    en_cnt  = 0;
    send(OP_RUN, 16'd0);
    send(OP_RUN, 16'd0);
    checks++;
    if ({cmd_err, state} !== {1'b1, 2'd1}) begin errors++; $display("FAIL run_in_run_err got=%b exp=101", {cmd_err, state}); end
    step();
    sb.push_back({2'd3, 3'd4, 32'd3, 32'd3, 32'd3});
    send(OP_STOP, 16'd0);
    got = {state, stop_reason, inst_cnt, cycle_cnt, en_cnt};
    expv = sb.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("FAIL stop_halt_outcome got=%h exp=%h", got, expv); end
    checks++;
    if (cmd_err !== 1'b0) begin errors++; $display("FAIL stop_halt_err got=%b exp=0", cmd_err); end
    send(OP_CLEAR, 16'd0);
    halt_pc = 32'hFFFF_FFFF;
  endtask

  task automatic test_step_zero();
    load_pc(32'h40);
    en_cnt = 0;
    sb.push_back({2'd0, 3'd2, 32'd1, 32'd1, 32'd1});
    send(OP_STEP, 16'd0);
    run_until_stop(to);
    checks++;
    if (to) begin errors++; $display("FAIL step0_timeout state=%0d exp=0", state); end
    got = {state, stop_reason, inst_cnt, cycle_cnt, en_cnt};
    expv = sb.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("FAIL step0_outcome got=%h exp=%h", got, expv); end
    send(OP_STOP, 16'd0);
    checks++;
    if ({state, stop_reason, cmd_err} !== {2'd0, 3'd2, 1'b0}) begin
      errors++; $display("FAIL idle_stop_noop got=%b exp=000100", {state, stop_reason, cmd_err});
    end
    send(OP_CLEAR, 16'd0);
  endtask

  task automatic test_async_reset();
    load_pc(32'd0);
    send(OP_RUN, 16'd0);
    step();
    step();
    checks++;
    if ({global_en, state} !== {1'b1, 2'd1}) begin errors++; $display("FAIL pre_rst got=%b exp=101", {global_en, state}); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (global_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", global_en); end
    checks++;
    if ({state, stop_reason, cmd_err, inst_cnt, cycle_cnt} !== 70'd0) begin
      errors++; $display("FAIL rst_outputs got=%h exp=0", {state, stop_reason, cmd_err, inst_cnt, cycle_cnt});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_step3();
    test_breakpoint();
    test_halt();
    test_stop_vs_halt();
    test_step_zero();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/breakpoint controller for the single-cycle CPU core. It generates the core's global_en from host debug commands and stops execution on step completion, a PC breakpoint, a STOP command or the halt instruction (32'h8000_0000). It sits beside the CPU at top level, observes the fetch PC and instruction, and keeps enabled-cycle and retired-instruction counters for the debug host.

Parameters:
HALT_INST, 32'h8000_0000, instruction encoding that ends execution
STEP_W, 16, width of the step-count operand

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
cmd_valid  input  1  one-cycle command strobe
cmd_op  input  2  0 RUN, 1 STEP, 2 STOP, 3 CLEAR
cmd_step_n  input  STEP_W  instruction count for STEP; 0 is treated as 1
bp_en  input  1  breakpoint enable
bp_addr  input  32  breakpoint PC
pc  input  32  current fetch PC (core imem_raddr)
inst  input  32  current fetched instruction (core imem_rdata)
global_en  output  1  core enable, combinational
state  output  2  0 IDLE, 1 RUN, 2 STEP, 3 HALTED
stop_reason  output  3  0 none, 1 STOP cmd, 2 step done, 3 breakpoint, 4 halt
cmd_err  output  1  one-cycle pulse: command illegal in current state
cycle_cnt  output  32  cycles spent in RUN or STEP, saturating
inst_cnt  output  32  cycles with global_en=1 (instructions executed), saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, stop_reason=0, cmd_err=0, cycle_cnt=0, inst_cnt=0, step_left=0, skip=0. global_en=0.
- bp_hit = bp_en & (pc==bp_addr) & ~skip.
- global_en = (state==RUN | state==STEP) & ~bp_hit. It is combinational, with no added latency. One enabled cycle executes and retires exactly one instruction.
- skip is set when RUN or STEP is accepted. It is cleared at the end of the first cycle with global_en=1. The instruction at a breakpoint therefore executes on resume.
- Commands are sampled when cmd_valid=1. Every command is consumed in one cycle, with no backpressure.
  - IDLE: RUN -> RUN. STEP -> STEP with step_left=max(cmd_step_n,1). STOP is a no-op. CLEAR zeroes both counters and stop_reason.
  - RUN/STEP: STOP -> IDLE with reason 1. RUN, STEP and CLEAR -> cmd_err.
  - HALTED: CLEAR -> IDLE, zeroes counters, reason 0. Any other command -> cmd_err.
  - Accepting RUN or STEP clears stop_reason to 0.
- RUN/STEP transitions, evaluated each cycle in priority order:
  1. global_en & inst==HALT_INST -> HALTED, reason 4. The halt instruction itself executes and is counted.
  2. bp_hit -> IDLE, reason 3. The instruction at bp_addr does not execute.
  3. STOP command -> IDLE, reason 1. The current cycle's instruction still executes, because global_en is already high.
  4. STEP & global_en & step_left==1 -> IDLE, reason 2. Otherwise, when global_en=1 in STEP, step_left decrements.
- Simultaneous events: halt beats STOP and step completion. A breakpoint beats STOP. A halt at the last step gives HALTED.
- Counters: cycle_cnt increments each cycle state is RUN or STEP, including a bp_hit cycle. inst_cnt increments each cycle global_en=1. Both saturate at 32'hFFFF_FFFF. CLEAR has priority over the increment.
- cmd_err is registered and appears the cycle after the offending command. It is high for one cycle.
- Outputs state, stop_reason, cmd_err and the counters are registered.

Decomposition:
- Shared package: state encodings, cmd_op encodings, stop_reason encodings, HALT_INST constant. The core uses the same HALT constant.
- One sub-module is natural: sat_counter (32-bit, inc/clr inputs, saturating), instantiated twice.
- FSM and step/skip logic stay in cpu_run_ctrl.

Test Plan:
- Reset then STEP with cmd_step_n=3, pc advancing 0,4,8,12 -> global_en high exactly 3 cycles. Then state=IDLE, reason=2, inst_cnt=3, cycle_cnt=3.
- bp_en=1, bp_addr=0x10, RUN from pc=0 -> global_en drops when pc=0x10; IDLE, reason=3, inst_cnt=4. Then RUN again -> the instruction at 0x10 executes (inst_cnt=5) and the run continues.
- RUN, inst=32'h8000_0000 at pc=0x8 -> halt executes; HALTED, reason=4, inst_cnt=3. Then RUN -> cmd_err pulse. Then CLEAR -> IDLE, counters=0.
- STOP during RUN on the same cycle as inst=HALT_INST -> HALTED, reason=4. STOP alone mid-run -> IDLE, reason=1, and that cycle's instruction is counted.
- STEP with cmd_step_n=0 -> exactly one instruction; reason=2.
- rst asserted mid-RUN, asynchronously between clock edges -> global_en falls immediately; all outputs return to their reset values before the next edge.
